// File: rtl/reg_alu_seq.sv
// rtl/reg_alu_seq.sv - instruction sequencer driving register-file/ALU datapath controls
module reg_alu_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic             sel,
    output logic             wr,
    output logic [1:0]       op,
    output logic [2:0]       rd_addr_a,
    output logic [2:0]       rd_addr_b,
    output logic [2:0]       wr_addr,
    output logic [15:0]      d_in,
    output logic             halted,
    output logic [CNT_W-1:0] wr_count
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_IMM   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    localparam logic [1:0] C_LDI  = 2'b01;
    localparam logic [1:0] C_ALU  = 2'b10;
    localparam logic [1:0] C_HALT = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [2:0]       r_rd_lat;
    logic             r_sel;
    logic             r_wr;
    logic [1:0]       r_op;
    logic [2:0]       r_ra;
    logic [2:0]       r_rb;
    logic [2:0]       r_wa;
    logic [15:0]      r_din;
    logic [CNT_W-1:0] r_cnt;

    logic w_ready;
    logic w_accept;

    // Ready depends only on registered state so it never loops back through instr_valid.
    assign w_ready  = (r_state != S_HALT);
    assign w_accept = instr_valid & w_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_rd_lat <= 3'd0;
            r_sel    <= 1'b0;
            r_wr     <= 1'b0;
            r_op     <= 2'd0;
            r_ra     <= 3'd0;
            r_rb     <= 3'd0;
            r_wa     <= 3'd0;
            r_din    <= 16'd0;
            r_cnt    <= '0;
        end else begin
            r_wr <= 1'b0;
            if (w_accept) begin
                if (r_state == S_IMM) begin
                    // Second word of LDI is raw data regardless of its class bits.
                    r_sel   <= 1'b0;
                    r_wr    <= 1'b1;
                    r_din   <= instr;
                    r_wa    <= r_rd_lat;
                    r_cnt   <= r_cnt + CNT_ONE;
                    r_state <= S_FETCH;
                end else begin
                    case (instr[15:14])
                        C_ALU: begin
                            r_sel <= 1'b1;
                            r_wr  <= 1'b1;
                            r_op  <= instr[13:12];
                            r_wa  <= instr[11:9];
                            r_ra  <= instr[8:6];
                            r_rb  <= instr[5:3];
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                        C_LDI: begin
                            r_rd_lat <= instr[11:9];
                            r_state  <= S_IMM;
                        end
                        C_HALT: begin
                            r_state <= S_HALT;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign instr_ready = w_ready;
    assign sel         = r_sel;
    assign wr          = r_wr;
    assign op          = r_op;
    assign rd_addr_a   = r_ra;
    assign rd_addr_b   = r_rb;
    assign wr_addr     = r_wa;
    assign d_in        = r_din;
    assign halted      = (r_state == S_HALT);
    assign wr_count    = r_cnt;
endmodule

// File: tb/tb_reg_alu_seq.sv
// tb/tb_reg_alu_seq.sv - randomized and directed bench for reg_alu_seq against a behavioural model
module tb_reg_alu_seq;
    localparam int CNT_W = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             instr_valid = 1'b0;
    logic [15:0]      instr = 16'd0;
    logic             instr_ready;
    logic             sel;
    logic             wr;
    logic [1:0]       op;
    logic [2:0]       rd_addr_a;
    logic [2:0]       rd_addr_b;
    logic [2:0]       wr_addr;
    logic [15:0]      d_in;
    logic             halted;
    logic [CNT_W-1:0] wr_count;

    int total = 0;
    int bad = 0;

    reg_alu_seq #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .sel(sel), .wr(wr), .op(op),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
        .d_in(d_in), .halted(halted), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Model: halted flag, pending-immediate flag with its target, last-issued control values.
    bit m_halt, m_pend;
    int m_rd;
    int e_sel, e_wr, e_op, e_ra, e_rb, e_wa, e_din, e_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_halt = 0; m_pend = 0; m_rd = 0;
            e_sel = 0; e_wr = 0; e_op = 0; e_ra = 0; e_rb = 0; e_wa = 0; e_din = 0; e_cnt = 0;
        end else begin
            e_wr = 0;
            if (instr_valid && !m_halt) begin
                if (m_pend) begin
                    e_sel = 0; e_wr = 1; e_din = int'(instr); e_wa = m_rd;
                    e_cnt = (e_cnt + 1) % CNT_MOD;
                    m_pend = 0;
                end else if (instr[15:14] == 2'b10) begin
                    e_sel = 1; e_wr = 1;
                    e_op = int'(instr) / 4096 % 4;
                    e_wa = int'(instr) / 512 % 8;
                    e_ra = int'(instr) / 64 % 8;
                    e_rb = int'(instr) / 8 % 8;
                    e_cnt = (e_cnt + 1) % CNT_MOD;
                end else if (instr[15:14] == 2'b01) begin
                    m_pend = 1; m_rd = int'(instr) / 512 % 8;
                end else if (instr[15:14] == 2'b11) begin
                    m_halt = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ready", int'(instr_ready), m_halt ? 0 : 1);
        chk("halted", int'(halted), m_halt ? 1 : 0);
        chk("wr", int'(wr), e_wr);
        chk("wr_count", int'(wr_count), e_cnt);
        chk("sel", int'(sel), e_sel);
        chk("op", int'(op), e_op);
        chk("rd_addr_a", int'(rd_addr_a), e_ra);
        chk("rd_addr_b", int'(rd_addr_b), e_rb);
        chk("wr_addr", int'(wr_addr), e_wa);
        chk("d_in", int'(d_in), e_din);
    end

    task automatic drive(input logic v, input logic [15:0] w);
        @(negedge clk);
        #1;
        instr_valid = v;
        instr = w;
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        #1;
        reset = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            drive(0, 16'h0);
            chk("lit_idle_ready", int'(instr_ready), 1);
            chk("lit_idle_wr", int'(wr), 0);
            chk("lit_idle_halted", int'(halted), 0);
            chk("lit_idle_cnt", int'(wr_count), 0);
        end

        drive(1, 16'h9650);
        drive(0, 16'h0);
        chk("lit_alu_sel", int'(sel), 1);
        chk("lit_alu_wr", int'(wr), 1);
        chk("lit_alu_op", int'(op), 1);
        chk("lit_alu_ra", int'(rd_addr_a), 1);
        chk("lit_alu_rb", int'(rd_addr_b), 2);
        chk("lit_alu_wa", int'(wr_addr), 3);
        drive(0, 16'h0);
        chk("lit_alu_wr_after", int'(wr), 0);
        chk("lit_alu_cnt", int'(wr_count), 1);

        rst_pulse();
        drive(1, 16'h4A00);
        for (int i = 0; i < 3; i++) begin
            drive(0, 16'h0);
            chk("lit_ldi_gap_wr", int'(wr), 0);
        end
        drive(1, 16'h1234);
        drive(0, 16'h0);
        chk("lit_ldi_wr", int'(wr), 1);
        chk("lit_ldi_sel", int'(sel), 0);
        chk("lit_ldi_wa", int'(wr_addr), 5);
        chk("lit_ldi_din", int'(d_in), 16'h1234);
        chk("lit_ldi_cnt", int'(wr_count), 1);

        rst_pulse();
        for (int i = 0; i < 4; i++) begin
            drive(1, {2'b10, 2'(i), 3'(i + 1), 3'(i), 3'(7 - i), 3'b0});
            if (i > 0) chk("lit_stream_wr", int'(wr), 1);
        end
        drive(1, 16'h0000);
        chk("lit_stream_wr_last", int'(wr), 1);
        drive(0, 16'h0);
        chk("lit_nop_wr", int'(wr), 0);
        chk("lit_stream_cnt", int'(wr_count), 4);

        drive(1, 16'hC000);
        drive(1, 16'h9650);
        chk("lit_halt_halted", int'(halted), 1);
        chk("lit_halt_ready", int'(instr_ready), 0);
        drive(1, 16'h9650);
        chk("lit_halt_wr", int'(wr), 0);
        chk("lit_halt_cnt", int'(wr_count), 4);

        rst_pulse();
        drive(1, 16'h4A00);
        rst_pulse();
        drive(1, 16'h1234);
        drive(0, 16'h0);
        chk("lit_rst_imm_wr", int'(wr), 0);
        chk("lit_rst_imm_cnt", int'(wr_count), 0);

        for (int i = 0; i < CNT_MOD; i++) begin
            drive(1, 16'h8000 | 16'($urandom_range(0, 16'h3FFF)));
            if (i == CNT_MOD - 1) chk("lit_wrap_pre", int'(wr_count), CNT_MOD - 1);
        end
        drive(0, 16'h0);
        chk("lit_wrap_cnt", int'(wr_count), 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst_pulse();
            end else begin
                logic [15:0] w;
                w = 16'($urandom);
                if (w[15:14] == 2'b11 && $urandom_range(0, 15) != 0) w[15] = 1'b0;
                drive(($urandom_range(0, 3) != 0), w);
            end
        end

        drive(0, 16'h0);
        drive(0, 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_alu_seq.md
Name: reg_alu_seq

Overview:
Instruction sequencer that sits directly upstream of the register-file/ALU datapath and drives all of its control inputs.
- Accepts 16-bit instruction words over a valid/ready handshake.
- Decodes each word into register-file write/read addresses, an ALU op and a source select.
- Issues at most one register write per cycle.
- Counts issued writes and halts on a HALT instruction.

Parameters:
CNT_W, 8, width of the issued-write counter wr_count.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
instr_valid  input  1  instr holds a valid word this cycle
instr  input  16  instruction word or LDI immediate word
instr_ready  output  1  sequencer can accept a word this cycle
sel  output  1  datapath write-source select: 0 = d_in, 1 = ALU result
wr  output  1  datapath register-file write enable
op  output  2  ALU operation code, passed through from the instruction
rd_addr_a  output  3  register read address, port A
rd_addr_b  output  3  register read address, port B
wr_addr  output  3  register write address
d_in  output  16  immediate data for the datapath
halted  output  1  high once HALT has been accepted
wr_count  output  CNT_W  number of writes issued, modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. While reset is high, all outputs and state are zero and the state is S_FETCH.
- Handshake:
  - A word transfers on a rising edge where instr_valid = 1 and instr_ready = 1.
  - instr_ready is a function of registered state only; it never depends on instr_valid.
  - instr_ready = 1 in S_FETCH and S_IMM, 0 in S_HALT.
- Instruction format (fields by bit position):
  - [15:14] class: 00 NOP, 01 LDI, 10 ALU, 11 HALT.
  - [13:12] op.
  - [11:9] rd.
  - [8:6] ra.
  - [5:3] rb.
  - [2:0] reserved; ignored.
- All control outputs are registered. Values loaded at the accepting edge E are presented during the cycle after E, so the datapath writes at edge E+1.
- wr is high for exactly one cycle per issued write and is 0 in every other cycle. All other control outputs hold their last value when not issuing.
- S_FETCH, on accepting a word:
  - NOP: no write; stay in S_FETCH.
  - ALU: sel=1, wr=1, op=[13:12], rd_addr_a=ra, rd_addr_b=rb, wr_addr=rd; stay in S_FETCH. Back-to-back ALU words issue one per cycle with no bubble.
  - LDI: latch rd internally; no write yet; go to S_IMM.
  - HALT: go to S_HALT; halted=1 from the next cycle.
- S_IMM: the next accepted word is the immediate, whatever its class bits. On acceptance: sel=0, wr=1, d_in=word, wr_addr=latched rd; return to S_FETCH. While instr_valid=0, wait indefinitely with no write.
- S_HALT: no writes; instr_ready=0; only reset exits.
- wr_count increments by 1 on each edge that loads wr=1 (ALU accept or LDI immediate accept). It wraps from 2^CNT_W-1 to 0.
- Writes to rd=0 are issued normally (wr=1, wr_addr=0) and counted; the datapath keeps r0 at zero.
- Reset asserted in S_IMM discards the pending LDI: no write, wr_count=0, state S_FETCH.
- Reset asserted while wr=1 forces wr=0 immediately (asynchronous).

Test Plan:
- Reset, then instr_valid=0 for 5 cycles -> instr_ready=1, wr=0, halted=0, wr_count=0 throughout.
- ALU word 16'h9650 (op=01, rd=3, ra=1, rb=2) accepted at edge E -> in cycle after E: sel=1, wr=1, op=01, rd_addr_a=1, rd_addr_b=2, wr_addr=3; wr=0 the following cycle if no new word; wr_count=1.
- LDI 16'h4A00, then instr_valid=0 for 3 cycles, then 16'h1234 -> no write during the gap; one cycle with sel=0, wr=1, wr_addr=5, d_in=16'h1234; wr_count=1.
- Stream of 4 ALU words on consecutive cycles, then NOP 16'h0000 -> wr high for exactly 4 consecutive cycles; wr_count=4; NOP produces no write.
- HALT 16'hC000 followed by valid ALU words -> halted=1 and instr_ready=0 from the next cycle; no further writes; wr_count unchanged.
- Reset pulse in S_IMM after 16'h4A00, then 16'h1234 -> 16'h1234 decodes as a NOP (class 00), no write; after 2^CNT_W=256 ALU issues, wr_count wraps to 0.
